load_use_hazard_unit: RTL and testbench

Decode-stage hazard detector that sits directly upstream of the forwarding logic. It tracks the destination registers and load flags of the two instructions ahead of decode, and stalls the instruction in decode when forwarding cannot resolve its operand dependence. Two cases stall: load-use into the ALU, and any producer feeding the ID-stage branch compare or jump-register. While stalled it holds IF/ID and inserts a bubble into ID/EX, so downstream forwarding only ever sees resolvable dependences.

---
 rtl/load_use_hazard_unit.sv | 113 +++++++++++
 tb/tb_load_use_hazard_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/load_use_hazard_unit.sv
// load_use_hazard_unit: decode-stage stall/bubble generator for load-use and ID-branch dependences.
// Latency: stall is combinational in the cycle the consumer sits in ID; history advances on CLK rise.
// Backpressure: HAZ_STALL holds PC/IF-ID; FREEZE_IN holds all state and masks outputs. HAZARD_PERF_CNT_EN builds the stall counter.
module load_use_hazard_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr,
  input  logic        RegWrite,
  input  logic        RegDest,
  input  logic        Link,
  input  logic        MemRead,
  input  logic        RsUsed,
  input  logic        RtUsed,
  input  logic        Branch,
  input  logic        FREEZE_IN,
  output logic        HAZ_STALL,
  output logic        HAZ_BUBBLE,
  output logic [1:0]  HAZ_REASON,
  output logic [31:0] HAZ_STALL_CNT
);

  typedef struct packed {
    logic [4:0] dest;
    logic       is_load;
  } hist_t;

  hist_t      h0;  // instruction in EX
  hist_t      h1;  // instruction in MEM
  hist_t      h0_nxt;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] dest;
  logic       m0s, m0t, m1s, m1t;
  logic       m0, m1;
  logic       stall_raw;
  logic [1:0] reason_raw;
  logic       unused_instr_bits;

  assign rs = Instr[25:21];
  assign rt = Instr[20:16];
  assign unused_instr_bits = ^{Instr[31:26], Instr[10:0]};

  always_comb begin
    dest = 5'd0;
    if (!RegWrite)    dest = 5'd0;
    else if (Link)    dest = 5'd31;
    else if (RegDest) dest = Instr[15:11];
    else              dest = Instr[20:16];
  end

  // Register 0 is hardwired, so a zero destination never creates a dependence.
  assign m0s = RsUsed && (h0.dest == rs) && (h0.dest != 5'd0);
  assign m0t = RtUsed && (h0.dest == rt) && (h0.dest != 5'd0);
  assign m1s = RsUsed && (h1.dest == rs) && (h1.dest != 5'd0);
  assign m1t = RtUsed && (h1.dest == rt) && (h1.dest != 5'd0);
  assign m0  = m0s || m0t;
  assign m1  = m1s || m1t;

  always_comb begin
    stall_raw  = 1'b0;
    reason_raw = 2'b00;
    if (Branch && m1 && h1.is_load) begin
      stall_raw  = 1'b1;
      reason_raw = 2'b11;
    end else if (Branch && m0) begin
      stall_raw  = 1'b1;
      reason_raw = h0.is_load ? 2'b11 : 2'b10;
    end else if (!Branch && m0 && h0.is_load) begin
      stall_raw  = 1'b1;
      reason_raw = 2'b01;
    end
  end

  // The global freeze already holds every stage, so local stall requests are masked.
  assign HAZ_STALL  = stall_raw && !FREEZE_IN;
  assign HAZ_BUBBLE = HAZ_STALL;
  assign HAZ_REASON = FREEZE_IN ? 2'b00 : reason_raw;

  always_comb begin
    h0_nxt = '0;
    if (!stall_raw) begin
      h0_nxt.dest    = dest;
      h0_nxt.is_load = MemRead && RegWrite;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      h0 <= '0;
      h1 <= '0;
    end else if (!FREEZE_IN) begin
      h1 <= h0;
      h0 <= h0_nxt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stall_cnt <= 32'd0;
    end else if (HAZ_STALL && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign HAZ_STALL_CNT = stall_cnt;
`else
  assign HAZ_STALL_CNT = 32'd0;
`endif

endmodule

// File: tb/tb_load_use_hazard_unit.sv
// Scoreboard bench for load_use_hazard_unit: driver queues expected outputs, negedge monitor compares.
module tb_load_use_hazard_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr;
  logic        RegWrite, RegDest, Link, MemRead, RsUsed, RtUsed, Branch;
  logic        FREEZE_IN;
  logic        HAZ_STALL, HAZ_BUBBLE;
  logic [1:0]  HAZ_REASON;
  logic [31:0] HAZ_STALL_CNT;

  // {RegWrite, RegDest, Link, MemRead, RsUsed, RtUsed, Branch}
  localparam logic [6:0] C_NOP = 7'b0000000;
  localparam logic [6:0] C_LW  = 7'b1001100;
  localparam logic [6:0] C_ADD = 7'b1100110;
  localparam logic [6:0] C_BEQ = 7'b0000111;
  localparam logic [6:0] C_JR  = 7'b0000101;
  localparam logic [6:0] C_JAL = 7'b1010000;

  typedef struct packed {
    logic        stall;
    logic [1:0]  reason;
    logic [31:0] cnt;
    logic [15:0] id;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] vec_id = 16'd0;
  logic [31:0] exp_cnt = 32'd0;

  always #5 CLK = ~CLK;

  load_use_hazard_unit dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .Instr        (Instr),
    .RegWrite     (RegWrite),
    .RegDest      (RegDest),
    .Link         (Link),
    .MemRead      (MemRead),
    .RsUsed       (RsUsed),
    .RtUsed       (RtUsed),
    .Branch       (Branch),
    .FREEZE_IN    (FREEZE_IN),
    .HAZ_STALL    (HAZ_STALL),
    .HAZ_BUBBLE   (HAZ_BUBBLE),
    .HAZ_REASON   (HAZ_REASON),
    .HAZ_STALL_CNT(HAZ_STALL_CNT)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input logic [15:0] id);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check("stall",  {31'd0, HAZ_STALL},  {31'd0, mon_e.stall},  mon_e.id);
      check("bubble", {31'd0, HAZ_BUBBLE}, {31'd0, mon_e.stall},  mon_e.id);
      check("reason", {30'd0, HAZ_REASON}, {30'd0, mon_e.reason}, mon_e.id);
      check("cnt",    HAZ_STALL_CNT,       mon_e.cnt,             mon_e.id);
    end
  end

  task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [6:0] ctl, input logic frz);
    Instr = {6'd0, rs, rt, rd, 11'd0};
    {RegWrite, RegDest, Link, MemRead, RsUsed, RtUsed, Branch} = ctl;
    FREEZE_IN = frz;
  endtask

  task automatic push(input logic es, input logic [1:0] er);
    exp_t e;
    e.stall  = es;
    e.reason = er;
    e.cnt    = exp_cnt;
    e.id     = vec_id;
    sb_q.push_back(e);
    vec_id++;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [6:0] ctl, input logic frz, input logic es, input logic [1:0] er);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    apply(rs, rt, rd, ctl, frz);
    push(es, er);
`ifdef HAZARD_PERF_CNT_EN
    if (es && !frz) exp_cnt++;
`endif
  endtask

  // Asserts reset for one cycle while presenting the given instruction.
  task automatic rst_cycle(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [6:0] ctl, input logic frz);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    apply(rs, rt, rd, ctl, frz);
    exp_cnt = 32'd0;
    push(1'b0, 2'b00);
  endtask

  initial begin
    RESET = 1'b0;
    apply(5'd0, 5'd0, 5'd0, C_NOP, 1'b0);

    // Reset with arbitrary inputs
    for (int i = 0; i < 4; i++) begin
      rst_cycle(5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
                7'($urandom_range(127)), 1'($urandom_range(1)));
    end

    // lw r5 ; add r6,r5,r7 -> one load-use stall
    drive(5'd1, 5'd5, 5'd0, C_LW,  1'b0, 1'b0, 2'b00);
    drive(5'd5, 5'd7, 5'd6, C_ADD, 1'b0, 1'b1, 2'b01);
    drive(5'd5, 5'd7, 5'd6, C_ADD, 1'b0, 1'b0, 2'b00);
    drive(5'd0, 5'd0, 5'd0, C_NOP, 1'b0, 1'b0, 2'b00);

    // add r3 ; beq r3,r4 -> one stall, EX producer
    drive(5'd1, 5'd2, 5'd3, C_ADD, 1'b0, 1'b0, 2'b00);
    drive(5'd3, 5'd4, 5'd0, C_BEQ, 1'b0, 1'b1, 2'b10);
    drive(5'd3, 5'd4, 5'd0, C_BEQ, 1'b0, 1'b0, 2'b00);
    drive(5'd0, 5'd0, 5'd0, C_NOP, 1'b0, 1'b0, 2'b00);

    // lw r3 ; beq r0,r3 -> two stalls, reason 11
    drive(5'd1, 5'd3, 5'd0, C_LW,  1'b0, 1'b0, 2'b00);
    drive(5'd0, 5'd3, 5'd0, C_BEQ, 1'b0, 1'b1, 2'b11);
    drive(5'd0, 5'd3, 5'd0, C_BEQ, 1'b0, 1'b1, 2'b11);
    drive(5'd0, 5'd3, 5'd0, C_BEQ, 1'b0, 1'b0, 2'b00);
    drive(5'd0, 5'd0, 5'd0, C_NOP, 1'b0, 1'b0, 2'b00);

    // lw r3 ; nop ; jr r3 -> one stall, reason 11
    drive(5'd1, 5'd3, 5'd0, C_LW,  1'b0, 1'b0, 2'b00);
    drive(5'd0, 5'd0, 5'd0, C_NOP, 1'b0, 1'b0, 2'b00);
    drive(5'd3, 5'd0, 5'd0, C_JR,  1'b0, 1'b1, 2'b11);
    drive(5'd3, 5'd0, 5'd0, C_JR,  1'b0, 1'b0, 2'b00);
    drive(5'd0, 5'd0, 5'd0, C_NOP, 1'b0, 1'b0, 2'b00);

    // lw r0 ; add r1,r0,r0 -> no stall
    drive(5'd1, 5'd0, 5'd0, C_LW,  1'b0, 1'b0, 2'b00);
    drive(5'd0, 5'd0, 5'd1, C_ADD, 1'b0, 1'b0, 2'b00);
    drive(5'd0, 5'd0, 5'd0, C_NOP, 1'b0, 1'b0, 2'b00);

    // jal ; beq r31,r0 -> one stall, reason 10
    drive(5'd0, 5'd0, 5'd0, C_JAL, 1'b0, 1'b0, 2'b00);
    drive(5'd31, 5'd0, 5'd0, C_BEQ, 1'b0, 1'b1, 2'b10);
    drive(5'd31, 5'd0, 5'd0, C_BEQ, 1'b0, 1'b0, 2'b00);
    drive(5'd0, 5'd0, 5'd0, C_NOP, 1'b0, 1'b0, 2'b00);

    // ALU producer into ALU consumers (EX and MEM distance) -> no stall
    drive(5'd1, 5'd1, 5'd2, C_ADD, 1'b0, 1'b0, 2'b00);
    drive(5'd2, 5'd2, 5'd4, C_ADD, 1'b0, 1'b0, 2'b00);
    drive(5'd2, 5'd0, 5'd5, C_ADD, 1'b0, 1'b0, 2'b00);
    drive(5'd0, 5'd0, 5'd0, C_NOP, 1'b0, 1'b0, 2'b00);

    // Freeze during a load-use stall, then release
    drive(5'd1, 5'd5, 5'd0, C_LW,  1'b0, 1'b0, 2'b00);
    drive(5'd5, 5'd7, 5'd6, C_ADD, 1'b1, 1'b0, 2'b00);
    drive(5'd5, 5'd7, 5'd6, C_ADD, 1'b1, 1'b0, 2'b00);
    drive(5'd5, 5'd7, 5'd6, C_ADD, 1'b0, 1'b1, 2'b01);
    drive(5'd5, 5'd7, 5'd6, C_ADD, 1'b0, 1'b0, 2'b00);
    drive(5'd0, 5'd0, 5'd0, C_NOP, 1'b0, 1'b0, 2'b00);

    // Reset pulse in the middle of a stall
    drive(5'd1, 5'd5, 5'd0, C_LW,  1'b0, 1'b0, 2'b00);
    drive(5'd5, 5'd7, 5'd6, C_ADD, 1'b0, 1'b1, 2'b01);
    rst_cycle(5'd5, 5'd7, 5'd6, C_ADD, 1'b0);
    drive(5'd5, 5'd7, 5'd6, C_ADD, 1'b0, 1'b0, 2'b00);
    drive(5'd0, 5'd0, 5'd0, C_NOP, 1'b0, 1'b0, 2'b00);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge CLK);
    if (sb_q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
